// File: rtl/match_event_monitor_pkg.sv
// Shared types and default sizing for the match event monitor.
package seq_mon_pkg;

    typedef enum logic [1:0] {
        ARM_WAIT = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2
    } state_e;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_WINDOW_LEN = 64;
    localparam int DEF_THRESH     = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         at_max
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign at_max = &value_q;
    assign value  = value_q;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && !at_max) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/match_event_monitor.sv
// Turns the recognizer's level output into single events, keeps a saturating
// total and a per-window count, and raises an alarm on busy windows.
module match_event_monitor
    import seq_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WINDOW_LEN = DEF_WINDOW_LEN,
    parameter int THRESH     = DEF_THRESH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          match_in,
    input  logic                          enable,
    input  logic                          clear,
    output logic                          match_pulse,
    output logic [CNT_W-1:0]              total_count,
    output logic                          total_sat,
    output logic [CNT_W-1:0]              window_count,
    output logic                          window_done,
    output logic                          alarm,
    output state_e                        dbg_state,
    output logic [$clog2(WINDOW_LEN)-1:0] dbg_phase
);

    localparam int               PH_W     = $clog2(WINDOW_LEN);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    state_e            state_q;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  window_count_q, window_count_d;
    logic              alarm_q, alarm_d;
    logic              window_done_q, window_done_d;
    logic              match_pulse_q, match_pulse_d;

    logic              edge_det;
    logic              accepted;
    logic              last_phase;
    logic [CNT_W-1:0]  win_acc;
    logic              win_at_max;
    logic [CNT_W-1:0]  win_sum;
    logic              total_at_max;

    assign edge_det   = (state_q == IDLE) && match_in;
    assign accepted   = edge_det && enable && !clear;
    assign last_phase = (phase_q == PH_LAST);

    // ARM_WAIT swallows a level already high out of reset; clear does not
    // disturb tracking so no phantom edge appears afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARM_WAIT;
        end else begin
            case (state_q)
                ARM_WAIT: if (!match_in) state_q <= IDLE;
                IDLE:     if (match_in)  state_q <= HIGH;
                HIGH:     if (!match_in) state_q <= IDLE;
                default:                 state_q <= ARM_WAIT;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_total (
        .clk    (clk),
        .reset  (reset),
        .inc    (accepted),
        .clr    (clear),
        .value  (total_count),
        .at_max (total_at_max)
    );

    sat_counter #(.W(CNT_W)) u_win_acc (
        .clk    (clk),
        .reset  (reset),
        .inc    (accepted),
        .clr    (clear || last_phase),
        .value  (win_acc),
        .at_max (win_at_max)
    );

    // The boundary cycle's own event belongs to the window being closed.
    assign win_sum = (accepted && !win_at_max) ? win_acc + 1'b1 : win_acc;

    always_comb begin
        phase_d        = (clear || last_phase) ? '0 : phase_q + 1'b1;
        window_count_d = window_count_q;
        alarm_d        = alarm_q;
        if (clear) begin
            window_count_d = '0;
            alarm_d        = 1'b0;
        end else if (last_phase) begin
            window_count_d = win_sum;
            alarm_d        = (win_sum >= THRESH_C);
        end
        window_done_d  = last_phase && !clear;
        match_pulse_d  = accepted;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q        <= '0;
            window_count_q <= '0;
            alarm_q        <= 1'b0;
            window_done_q  <= 1'b0;
            match_pulse_q  <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            window_count_q <= window_count_d;
            alarm_q        <= alarm_d;
            window_done_q  <= window_done_d;
            match_pulse_q  <= match_pulse_d;
        end
    end

    // The total only drops back via clear or reset, so at_max is already sticky.
    assign total_sat    = total_at_max;
    assign match_pulse  = match_pulse_q;
    assign window_count = window_count_q;
    assign window_done  = window_done_q;
    assign alarm        = alarm_q;
    assign dbg_state    = state_q;
    assign dbg_phase    = phase_q;

endmodule

// File: tb/tb_match_event_monitor.sv
// Scenario bench for match_event_monitor: scoreboarded pulses and window results.
module tb_match_event_monitor;
    import seq_mon_pkg::*;

    localparam int CW = 3;
    localparam int WL = 64;
    localparam int TH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          match_in = 1'b1;
    logic          enable = 1'b1;
    logic          clear = 1'b0;
    logic          match_pulse;
    logic [CW-1:0] total_count;
    logic          total_sat;
    logic [CW-1:0] window_count;
    logic          window_done;
    logic          alarm;
    state_e        dbg_state;
    logic [5:0]    dbg_phase;

    match_event_monitor #(
        .CNT_W      (CW),
        .WINDOW_LEN (WL),
        .THRESH     (TH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .match_in     (match_in),
        .enable       (enable),
        .clear        (clear),
        .match_pulse  (match_pulse),
        .total_count  (total_count),
        .total_sat    (total_sat),
        .window_count (window_count),
        .window_done  (window_done),
        .alarm        (alarm),
        .dbg_state    (dbg_state),
        .dbg_phase    (dbg_phase)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    int            pulses = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW:0]   win_q[$];
    int            st = 0;
    int            ph = 0;
    logic [CW-1:0] exp_total = '0;
    bit            win_chk = 1'b0;

    // One clock cycle: drive inputs, advance the bench's own view, then check.
    task automatic cyc(input logic m, input logic en, input logic clr);
        logic          ed;
        logic          done_exp;
        logic [CW-1:0] e;
        logic [CW:0]   w;
        match_in = m;
        enable   = en;
        clear    = clr;
        ed = (st == 1) && m;
        case (st)
            0:       if (!m) st = 1;
            1:       if (m)  st = 2;
            default: if (!m) st = 1;
        endcase
        if (clr) begin
            exp_total = '0;
        end else if (ed && en) begin
            if (exp_total != {CW{1'b1}}) exp_total = exp_total + 1'b1;
            exp_q.push_back(exp_total);
        end
        done_exp = (ph == WL - 1) && !clr;
        ph = (clr || ph == WL - 1) ? 0 : ph + 1;
        @(posedge clk);
        #1;
        if (match_pulse === 1'b1) begin
            pulses++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pulse_unexpected: match_pulse=1 total_count=%0d, required no pulse", total_count);
            end else begin
                e = exp_q.pop_front();
                if (total_count !== e) begin
                    fails++;
                    $display("FAIL pulse_total: total_count=%0d, required %0d", total_count, e);
                end
            end
        end
        if (win_chk) begin
            tests++;
            if (window_done !== done_exp) begin
                fails++;
                $display("FAIL window_done_timing: window_done=%b, required %b (bench phase %0d)", window_done, done_exp, ph);
            end
            if (window_done === 1'b1 && win_q.size() > 0) begin
                w = win_q.pop_front();
                tests++;
                if ({alarm, window_count} !== w) begin
                    fails++;
                    $display("FAIL window_result: alarm=%b window_count=%0d, required alarm=%b window_count=%0d",
                             alarm, window_count, w[CW], w[CW-1:0]);
                end
            end
        end
    endtask

    task automatic check_queue_empty(input string name);
        tests++;
        if (exp_q.size() != 0 || win_q.size() != 0) begin
            fails++;
            $display("FAIL %s_missing: %0d pulses and %0d windows still pending, required 0", name, exp_q.size(), win_q.size());
            exp_q.delete();
            win_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({match_pulse, total_count, total_sat, window_count, window_done, alarm, dbg_phase} !== '0) begin
            fails++;
            $display("FAIL %s_outputs: pulse=%b total=%0d sat=%b win=%0d done=%b alarm=%b phase=%0d, required all 0",
                     name, match_pulse, total_count, total_sat, window_count, window_done, alarm, dbg_phase);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        match_in = 1'b1;
        @(posedge clk);
        #1;
        check_zero("reset");
        tests++;
        if (dbg_state !== ARM_WAIT) begin
            fails++;
            $display("FAIL reset_state: state=%0d, required %0d", dbg_state, ARM_WAIT);
        end
        reset = 1'b0;
        st = 0; ph = 0; exp_total = '0;
        for (int c = 0; c < 12; c++) begin
            cyc((c < 5 || c >= 8) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            if (c == 8) begin
                tests++;
                if (match_pulse !== 1'b1 || total_count !== 3'd1) begin
                    fails++;
                    $display("FAIL reset_first_pulse: pulse=%b total=%0d, required 1 and 1", match_pulse, total_count);
                end
            end
        end
        check_queue_empty("reset");
    endtask

    task automatic test_long_high();
        int p0;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        p0 = pulses;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0);
        tests++;
        if (pulses - p0 != 1 || total_count !== 3'd2 || dbg_state !== HIGH) begin
            fails++;
            $display("FAIL long_high: pulses=%0d total=%0d state=%0d, required 1, 2, %0d", pulses - p0, total_count, dbg_state, HIGH);
        end
        cyc(1'b0, 1'b1, 1'b0);
        check_queue_empty("long_high");
    endtask

    task automatic test_saturation();
        cyc(1'b0, 1'b1, 1'b1);
        check_zero("sat_pre_clear");
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
        end
        tests++;
        if (total_count !== 3'd7 || total_sat !== 1'b1) begin
            fails++;
            $display("FAIL saturate: total=%0d sat=%b, required 7 and 1", total_count, total_sat);
        end
        cyc(1'b0, 1'b1, 1'b1);
        check_zero("sat_clear");
        check_queue_empty("saturation");
    endtask

    task automatic run_window(input logic [WL-1:0] mask, input logic exp_alarm, input logic [CW-1:0] exp_cnt);
        win_q.push_back({exp_alarm, exp_cnt});
        for (int p = 0; p < WL; p++) cyc(mask[p], 1'b1, 1'b0);
    endtask

    task automatic test_window();
        logic [WL-1:0] m;
        cyc(1'b0, 1'b1, 1'b1);
        win_chk = 1'b1;
        m = '0; m[10] = 1'b1; m[20] = 1'b1; m[30] = 1'b1; m[40] = 1'b1;
        run_window(m, 1'b1, 3'd4);
        m = '0; m[5] = 1'b1; m[15] = 1'b1; m[25] = 1'b1;
        run_window(m, 1'b0, 3'd3);
        m = '0; m[10] = 1'b1; m[20] = 1'b1; m[30] = 1'b1; m[63] = 1'b1;
        run_window(m, 1'b1, 3'd4);
        m = '0; m[5] = 1'b1;
        run_window(m, 1'b0, 3'd1);
        cyc(1'b0, 1'b1, 1'b0);
        win_chk = 1'b0;
        check_queue_empty("window");
    endtask

    task automatic test_clear_edge();
        int p0;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        p0 = pulses;
        cyc(1'b1, 1'b1, 1'b1);
        tests++;
        if (match_pulse !== 1'b0 || total_count !== 3'd0 || dbg_state !== HIGH) begin
            fails++;
            $display("FAIL clear_edge: pulse=%b total=%0d state=%0d, required 0, 0, %0d", match_pulse, total_count, dbg_state, HIGH);
        end
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        tests++;
        if (match_pulse !== 1'b0 || total_count !== 3'd0 || dbg_state !== HIGH) begin
            fails++;
            $display("FAIL disabled_edge: pulse=%b total=%0d state=%0d, required 0, 0, %0d", match_pulse, total_count, dbg_state, HIGH);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        tests++;
        if (pulses - p0 != 1 || total_count !== 3'd1) begin
            fails++;
            $display("FAIL clear_edge_recovery: pulses=%0d total=%0d, required 1 and 1", pulses - p0, total_count);
        end
        cyc(1'b0, 1'b1, 1'b0);
        check_queue_empty("clear_edge");
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_zero("reset_mid");
        tests++;
        if (dbg_state !== ARM_WAIT) begin
            fails++;
            $display("FAIL reset_mid_state: state=%0d, required %0d", dbg_state, ARM_WAIT);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        st = 0; ph = 0; exp_total = '0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        tests++;
        if (match_pulse !== 1'b1 || total_count !== 3'd1) begin
            fails++;
            $display("FAIL reset_mid_rearm: pulse=%b total=%0d, required 1 and 1", match_pulse, total_count);
        end
        check_queue_empty("reset_mid");
    endtask

    initial begin
        test_reset();
        test_long_high();
        test_saturation();
        test_window();
        test_clear_edge();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
